// File: rtl/iram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : iram_ctrl_pkg
//  Purpose  : Shared definitions for the instruction-RAM responder: data
//             width, default RAM depth, the NOP fill value, loader FSM state
//             encodings and a byte-lane insert helper.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package iram_ctrl_pkg;

    localparam int              XLEN         = 32;
    localparam int              IRAM_AW_DEF  = 12;
    localparam logic [XLEN-1:0] NOP_INST_DEF = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_WRITE = 2'd2
    } ld_state_e;

    // Replace byte lane 'idx' (lane 0 = bits [7:0]) of 'word' with 'data'.
    function automatic logic [XLEN-1:0] lane_insert(
        input logic [XLEN-1:0] word,
        input logic [1:0]      idx,
        input logic [7:0]      data
    );
        logic [XLEN-1:0] res;
        res = word;
        res[{idx, 3'b000} +: 8] = data;
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/iram_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : iram_ctrl_if
//  Purpose  : Bundles the fetch read port and the byte-serial loader port of
//             the instruction RAM.
//  Ports    : master modport = requester side (IF stage / boot loader)
//               out: iram_en, inst_raddr, ld_start, ld_valid, ld_byte, ld_last
//               in : inst, ld_ready, core_hold, ld_words
//             slave modport  = iram_ctrl side (directions reversed)
//  Revision : 1.0 - initial release
// ============================================================================
interface iram_ctrl_if #(
    parameter int IRAM_AW = iram_ctrl_pkg::IRAM_AW_DEF
);
    import iram_ctrl_pkg::*;

    logic              iram_en;
    logic [XLEN-3:0]   inst_raddr;
    logic [XLEN-1:0]   inst;
    logic              ld_start;
    logic              ld_valid;
    logic [7:0]        ld_byte;
    logic              ld_last;
    logic              ld_ready;
    logic              core_hold;
    logic [IRAM_AW:0]  ld_words;

    modport master (
        output iram_en, inst_raddr, ld_start, ld_valid, ld_byte, ld_last,
        input  inst, ld_ready, core_hold, ld_words
    );

    modport slave (
        input  iram_en, inst_raddr, ld_start, ld_valid, ld_byte, ld_last,
        output inst, ld_ready, core_hold, ld_words
    );

endinterface
`default_nettype wire

// File: rtl/iram_sp.sv
`default_nettype none
// ============================================================================
//  Module   : iram_sp
//  Purpose  : Single-port synchronous RAM wrapper. Write has priority over
//             read; read data is registered and holds when not reading.
//             The array has no reset so a vendor macro can drop in here.
//  Ports    : clk   - clock
//             we    - write enable
//             re    - read enable
//             addr  - word address
//             wdata - write data
//             rdata - registered read data
//  Revision : 1.0 - initial release
// ============================================================================
module iram_sp #(
    parameter int AW = 12,
    parameter int DW = 32
) (
    input  wire logic          clk,
    input  wire logic          we,
    input  wire logic          re,
    input  wire logic [AW-1:0] addr,
    input  wire logic [DW-1:0] wdata,
    output logic      [DW-1:0] rdata
);

    logic [DW-1:0] r_mem [0:(2**AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end else if (re) begin
            rdata <= r_mem[addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/iram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : iram_ctrl
//  Purpose  : Instruction-RAM responder. Serves 1-cycle fetch reads and owns
//             a byte-serial little-endian program loader that holds the core
//             while it fills the RAM.
//  Ports    : clk   - clock, rising edge
//             rst_n - asynchronous active-low reset
//             bus   - iram_ctrl_if slave: fetch read port + loader port
//  Revision : 1.0 - initial release
// ============================================================================
module iram_ctrl
    import iram_ctrl_pkg::*;
#(
    parameter int              IRAM_AW  = IRAM_AW_DEF,
    parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DEF
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    iram_ctrl_if.slave bus
);

    localparam logic [IRAM_AW:0] C_WORDS_MAX = {1'b1, {IRAM_AW{1'b0}}};

    ld_state_e          r_state;
    ld_state_e          w_state_nxt;
    logic [IRAM_AW-1:0] r_ptr;
    logic [1:0]         r_byte_idx;
    logic [XLEN-1:0]    r_asm;
    logic               r_last;
    logic [IRAM_AW:0]   r_words;
    logic               r_nop_sel;

    logic               w_accept;
    logic               w_we;
    logic               w_re;
    logic [IRAM_AW-1:0] w_addr;
    logic [XLEN-1:0]    w_rdata;
    logic               w_unused_addr;

    // Upper word-address bits are intentionally ignored.
    assign w_unused_addr = ^bus.inst_raddr[XLEN-3:IRAM_AW];

    // A restart in the same cycle drops both a pending byte and a pending write.
    assign w_accept = (r_state == ST_LOAD)  && bus.ld_valid && !bus.ld_start;
    assign w_we     = (r_state == ST_WRITE) && !bus.ld_start;
    assign w_re     = (r_state == ST_IDLE)  && bus.iram_en;
    assign w_addr   = w_we ? r_ptr : bus.inst_raddr[IRAM_AW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (bus.ld_start) begin
            w_state_nxt = ST_LOAD;
        end else begin
            case (r_state)
                ST_IDLE:  w_state_nxt = ST_IDLE;
                ST_LOAD:  if (bus.ld_valid && (r_byte_idx == 2'd3 || bus.ld_last))
                              w_state_nxt = ST_WRITE;
                ST_WRITE: w_state_nxt = r_last ? ST_IDLE : ST_LOAD;
                default:  w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr      <= '0;
            r_byte_idx <= '0;
            r_asm      <= '0;
            r_last     <= 1'b0;
            r_words    <= '0;
        end else if (bus.ld_start) begin
            r_ptr      <= '0;
            r_byte_idx <= '0;
            r_asm      <= '0;
            r_last     <= 1'b0;
            r_words    <= '0;
        end else if (w_accept) begin
            r_asm      <= lane_insert(r_asm, r_byte_idx, bus.ld_byte);
            r_byte_idx <= r_byte_idx + 2'd1;
            if (r_byte_idx == 2'd3 || bus.ld_last) begin
                r_last <= bus.ld_last;
            end
        end else if (w_we) begin
            r_ptr      <= r_ptr + 1'b1;
            r_byte_idx <= '0;
            r_asm      <= '0;
            if (r_words != C_WORDS_MAX) begin
                r_words <= r_words + 1'b1;
            end
        end
    end

    // The RAM's read register has no reset, so inst is forced to NOP until a
    // real read lands after reset or after a load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nop_sel <= 1'b1;
        end else if (r_state != ST_IDLE) begin
            r_nop_sel <= 1'b1;
        end else if (bus.iram_en) begin
            r_nop_sel <= 1'b0;
        end
    end

    iram_sp #(
        .AW (IRAM_AW),
        .DW (XLEN)
    ) u_iram_sp (
        .clk   (clk),
        .we    (w_we),
        .re    (w_re),
        .addr  (w_addr),
        .wdata (r_asm),
        .rdata (w_rdata)
    );

    assign bus.inst      = r_nop_sel ? NOP_INST : w_rdata;
    assign bus.ld_ready  = (r_state == ST_LOAD);
    assign bus.core_hold = (r_state != ST_IDLE);
    assign bus.ld_words  = r_words;

endmodule
`default_nettype wire

// File: doc/iram_ctrl.md
# iram_ctrl

Instruction-RAM responder on the far end of the fetch interface. It answers `iram_en`/`inst_raddr` word reads from the IF stage with single-cycle synchronous read data on `inst`. It also owns a byte-serial program loader that fills the RAM through a little-endian byte stream while holding the core. It sits between the core top and the boot/debug loader; the future bus/cache path replaces only the array behind it.

## Interface
Parameters:
- `IRAM_AW`, 12: word-address width; depth = 2^IRAM_AW words.
- `NOP_INST`, 32'h0000_0013: value driven on `inst` during reset, load and hold.

Ports:
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `iram_en` input 1: fetch read enable from IF stage.
- `inst_raddr` input `XLEN-2`: word address; only bits [IRAM_AW-1:0] are used, upper bits ignored.
- `inst` output `XLEN`: read data, registered.
- `ld_start` input 1: pulse; begin a load at word 0.
- `ld_valid` input 1: loader byte valid.
- `ld_byte` input 8: loader byte.
- `ld_last` input 1: qualifies the final byte of the image.
- `ld_ready` output 1: byte accepted when `ld_valid & ld_ready`.
- `core_hold` output 1: high while loading; the top drives `if_valid` low and stalls the pipe with it.
- `ld_words` output IRAM_AW+1: words written in the current/last load, saturating at 2^IRAM_AW.

## Operation
- States: IDLE, LOAD, WRITE.
- **IDLE**
  - `ld_ready`=0, `core_hold`=0. Fetch reads are serviced.
  - `ld_start` -> LOAD; word pointer, byte index, `ld_words` and the assembly register clear to 0.
- **LOAD**
  - `ld_ready`=1, `core_hold`=1.
  - Each accepted byte goes to lane `byte_idx` (lane 0 = bits [7:0]), then `byte_idx`++.
  - When the 4th byte or a byte with `ld_last` is accepted -> WRITE. Lanes not yet filled are zero.
- **WRITE**
  - `ld_ready`=0. The assembled word is written at the pointer.
  - Pointer increments mod 2^IRAM_AW (wrap-around). `ld_words`++ saturating. Byte index and assembly register clear.
  - Next state: IDLE if the last flag was latched, else LOAD.
- **Fetch reads**, outside LOAD/WRITE: `iram_en`=1 -> `inst` <= mem[addr] at the next edge. `iram_en`=0 -> `inst` holds its value (supports pipe stalls).
- **During LOAD/WRITE:** `inst` <= `NOP_INST` every cycle; array read is suppressed.
- **Edge cases**
  - `ld_start` in LOAD or WRITE: restart. Pointer/count/byte index clear, partial word discarded, state LOAD. A pending WRITE in that same cycle is dropped.
  - `ld_start` with `ld_valid` in IDLE: start only; the byte is not accepted.
  - Reset mid-load: state IDLE, counters cleared. The array is not reset, so already-written words persist.
  - `ld_last` on the 4th byte: a single WRITE, then IDLE.

## Timing
- Reset values: `inst`=`NOP_INST`, `ld_ready`=0, `core_hold`=0, `ld_words`=0, state IDLE.
- Read latency: 1 cycle. Address presented with `iram_en` at edge N gives data on `inst` after edge N.
- Load throughput: 4 bytes + 1 WRITE cycle per word, i.e. 5 cycles/word with `ld_valid` held high.
- `core_hold` rises the cycle after `ld_start` is sampled and falls the cycle after the final WRITE.
- The first fetch after the load completes returns data from the loaded image; there is no read-during-write hazard because fetch is blocked while held.

## Structure
- Shared defines header: `XLEN`, `IRAM_AW` default, `NOP_INST`, and the state encodings (IDLE=2'd0, LOAD=2'd1, WRITE=2'd2).
- One sub-module, `iram_sp`: a single-port synchronous RAM wrapper (we, addr, wdata, rdata, no reset on the array) so it can be swapped for a vendor macro.
- The loader FSM, assembly register and read-data/NOP mux live in `iram_ctrl`.

## Test plan
- **Load and read back:** start, then stream bytes 78 56 34 12 EF BE AD DE with `ld_last` on the final byte.
  - `ld_words`=2; `core_hold` drops.
  - Reads at 0 and 1 give 0x12345678 and 0xDEADBEEF one cycle after `iram_en`.
- **Partial word:** stream 3 bytes AA BB CC with `ld_last` on CC -> word 0 = 0x00CCBBAA, `ld_words`=1.
- **Stall hold:** read addr 1 (result 0xDEADBEEF), then hold `iram_en`=0 with addr 0 for 3 cycles -> `inst` stays 0xDEADBEEF.
- **Wrap-around:** with `IRAM_AW`=2, load 5 words W0..W4.
  - `ld_words`=4 (saturated).
  - mem[0]=W4; mem[1..3]=W1..W3.
- **Restart:** pulse `ld_start` after 2 bytes of word 0, then load 0x11111111 -> word 0 = 0x11111111 and `ld_words`=1.
- **Reset mid-load:** assert `rst_n`=0 after word 0 is written.
  - `inst`=0x00000013, `core_hold`=0, `ld_words`=0.
  - Word 0 keeps the value written before reset.
